// File: rtl/inst_rom_loader.sv
// Instruction ROM responder backed by a loadable word RAM. A valid/ready stream fills the RAM
// while the core is held in reset; fetches return the addressed word combinationally.
module inst_rom_loader #(
    parameter int DEPTH_LOG2  = 10,
    parameter int RELEASE_DLY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rom_ce_i,
    input  logic [31:0]           rom_addr_i,
    output logic [31:0]           rom_data_o,
    input  logic                  load_start_i,
    input  logic [DEPTH_LOG2:0]   load_len_i,
    input  logic                  load_valid_i,
    input  logic [31:0]           load_data_i,
    output logic                  load_ready_o,
    output logic                  cpu_rst_o,
    output logic                  load_done_o,
    output logic                  load_err_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = (RELEASE_DLY > 1) ? $clog2(RELEASE_DLY) : 1;
    localparam logic [DEPTH_LOG2:0] DEPTH_W = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        HOLD,
        RUN
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [DEPTH_LOG2:0]   len_q;
    logic [DEPTH_LOG2:0]   wptr;
    logic [CW-1:0]         hold_cnt;
    logic                  done_q;
    logic                  err_q;

    logic [31:0]           mem [DEPTH];

    logic                  start_ok;
    logic                  len_over;
    logic [DEPTH_LOG2:0]   len_clamped;
    logic                  accept;
    logic                  last_word;
    logic                  hold_last;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic                  rd_addr_ok;
    logic                  unused_addr_bits;

    assign start_ok    = load_start_i && ((state == IDLE) || (state == RUN));
    assign len_over    = load_len_i > DEPTH_W;
    assign len_clamped = len_over ? DEPTH_W : load_len_i;
    assign accept      = (state == LOAD) && load_valid_i;
    assign last_word   = accept && ((wptr + 1'b1) == len_q);
    assign hold_last   = hold_cnt == CW'(RELEASE_DLY - 1);

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE, RUN: if (load_start_i) next_state = (len_clamped == '0) ? HOLD : LOAD;
            LOAD:      if (last_word)    next_state = HOLD;
            HOLD:      if (hold_last)    next_state = RUN;
            default:                     next_state = IDLE;
        endcase
    end

    // The done pulse is registered on the HOLD->RUN transition so it lines up with the first RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            len_q    <= '0;
            wptr     <= '0;
            hold_cnt <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state  <= next_state;
            done_q <= (next_state == RUN) && (state != RUN);
            if (start_ok) begin
                len_q <= len_clamped;
                wptr  <= '0;
                if (len_over) err_q <= 1'b1;
            end else if (accept) begin
                wptr <= wptr + 1'b1;
            end
            if ((state == HOLD) && !hold_last) hold_cnt <= hold_cnt + 1'b1;
            else                               hold_cnt <= '0;
        end
    end

    // Memory has no reset so a core reset does not wipe the loaded program.
    always_ff @(posedge clk) begin
        if (accept) mem[wptr[DEPTH_LOG2-1:0]] <= load_data_i;
    end

    assign rd_idx           = rom_addr_i[DEPTH_LOG2+1:2];
    assign rd_addr_ok       = rom_addr_i[31:DEPTH_LOG2+2] == '0;
    assign unused_addr_bits = ^rom_addr_i[1:0];
    assign rom_data_o       = (rom_ce_i && (state == RUN) && rd_addr_ok) ? mem[rd_idx] : 32'h0;

    assign load_ready_o = state == LOAD;
    assign cpu_rst_o    = state != RUN;
    assign load_done_o  = done_q;
    assign load_err_o   = err_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Self-checking bench for inst_rom_loader: directed loads, release timing, fetch tables,
// oversize length clamping, reload from RUN and reset in the middle of a load.
module tb_inst_rom_loader;

    localparam int DL    = 10;
    localparam int DEPTH = 1 << DL;
    localparam int DLY   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_ce_i;
    logic [31:0] rom_addr_i;
    logic [31:0] rom_data_o;
    logic        load_start_i;
    logic [DL:0] load_len_i;
    logic        load_valid_i;
    logic [31:0] load_data_i;
    logic        load_ready_o;
    logic        cpu_rst_o;
    logic        load_done_o;
    logic        load_err_o;

    int checks = 0;
    int fails  = 0;
    logic [31:0] model [DEPTH];

    typedef struct {
        logic        ce;
        logic [31:0] addr;
        logic [31:0] exp;
    } fetch_vec_t;

    fetch_vec_t vecs [8];

    inst_rom_loader #(.DEPTH_LOG2(DL), .RELEASE_DLY(DLY)) dut (
        .clk          (clk),
        .rst          (rst),
        .rom_ce_i     (rom_ce_i),
        .rom_addr_i   (rom_addr_i),
        .rom_data_o   (rom_data_o),
        .load_start_i (load_start_i),
        .load_len_i   (load_len_i),
        .load_valid_i (load_valid_i),
        .load_data_i  (load_data_i),
        .load_ready_o (load_ready_o),
        .cpu_rst_o    (cpu_rst_o),
        .load_done_o  (load_done_o),
        .load_err_o   (load_err_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ce, input logic [31:0] addr);
        rom_ce_i   = ce;
        rom_addr_i = addr;
        #1;
    endtask

    task automatic startLoad(input int len);
        load_start_i = 1'b1;
        load_len_i   = (DL+1)'(len);
        step();
        load_start_i = 1'b0;
        load_len_i   = '0;
    endtask

    task automatic streamWords(input int n, input bit gaps, input logic [31:0] base);
        int accepted = 0;
        int cycles   = 0;
        while (accepted < n && cycles < 4 * n + 20) begin
            load_valid_i = !(gaps && (cycles % 2 == 1));
            load_data_i  = base + 32'(accepted);
            #1;
            checkOutput("ready_in_load", {31'b0, load_ready_o}, 32'd1);
            if (load_valid_i && load_ready_o) begin
                model[accepted] = load_data_i;
                accepted++;
            end
            step();
            cycles++;
        end
        load_valid_i = 1'b0;
        checkOutput("words_accepted", 32'(accepted), 32'(n));
    endtask

    task automatic waitRun(input int expCycles);
        int n = 0;
        while (cpu_rst_o && n < 20) begin
            step();
            n++;
        end
        checkOutput("release_cycles", 32'(n), 32'(expCycles));
        checkOutput("done_pulse", {31'b0, load_done_o}, 32'd1);
        step();
        checkOutput("done_clears", {31'b0, load_done_o}, 32'd0);
    endtask

    task automatic fetchModel(input string name, input int idx);
        applyStimulus(1'b1, 32'(idx) << 2);
        checkOutput(name, rom_data_o, model[idx]);
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0000, 32'h2401_0001};
        vecs[1] = '{1'b1, 32'h0000_0004, 32'h2401_0002};
        vecs[2] = '{1'b1, 32'h0000_0008, 32'h2401_0003};
        vecs[3] = '{1'b1, 32'h0000_000C, 32'h2401_0004};
        vecs[4] = '{1'b1, 32'h0000_0006, 32'h2401_0002};
        vecs[5] = '{1'b0, 32'h0000_0004, 32'h0000_0000};
        vecs[6] = '{1'b1, 32'h0000_1000, 32'h0000_0000};
        vecs[7] = '{1'b1, 32'h8000_0008, 32'h0000_0000};

        rst = 1'b1; rom_ce_i = 1'b1; rom_addr_i = '0;
        load_start_i = 1'b0; load_len_i = '0; load_valid_i = 1'b0; load_data_i = '0;
        repeat (3) step();
        checkOutput("rst_cpu_rst", {31'b0, cpu_rst_o}, 32'd1);
        checkOutput("rst_ready", {31'b0, load_ready_o}, 32'd0);
        checkOutput("rst_done", {31'b0, load_done_o}, 32'd0);
        checkOutput("rst_err", {31'b0, load_err_o}, 32'd0);
        checkOutput("rst_data", rom_data_o, 32'h0);
        rst = 1'b0;
        step();
        checkOutput("idle_cpu_rst", {31'b0, cpu_rst_o}, 32'd1);

        // Back-to-back load, release timing and the fetch table
        startLoad(4);
        streamWords(4, 1'b0, 32'h2401_0001);
        checkOutput("t1_ready_after", {31'b0, load_ready_o}, 32'd0);
        checkOutput("t1_cpu_rst_hold", {31'b0, cpu_rst_o}, 32'd1);
        waitRun(DLY);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].ce, vecs[i].addr);
            checkOutput($sformatf("t1_fetch%0d", i), rom_data_o, vecs[i].exp);
        end

        // Reload from RUN with gaps in valid
        startLoad(4);
        checkOutput("t2_cpu_rst_rise", {31'b0, cpu_rst_o}, 32'd1);
        streamWords(4, 1'b1, 32'h3C00_0010);
        checkOutput("t2_ready_after", {31'b0, load_ready_o}, 32'd0);
        waitRun(DLY);
        for (int i = 0; i < 4; i++) fetchModel($sformatf("t2_fetch%0d", i), i);

        // Zero-length load keeps previous contents
        startLoad(0);
        checkOutput("t3_no_ready", {31'b0, load_ready_o}, 32'd0);
        checkOutput("t3_cpu_rst", {31'b0, cpu_rst_o}, 32'd1);
        waitRun(DLY);
        for (int i = 0; i < 4; i++) fetchModel($sformatf("t3_fetch%0d", i), i);
        checkOutput("t3_err", {31'b0, load_err_o}, 32'd0);

        // Oversize length is clamped to the memory depth
        startLoad(DEPTH + 5);
        checkOutput("t4_err_set", {31'b0, load_err_o}, 32'd1);
        streamWords(DEPTH, 1'b0, 32'hA000_0000);
        load_valid_i = 1'b1;
        #1;
        checkOutput("t4_no_extra_ready", {31'b0, load_ready_o}, 32'd0);
        load_valid_i = 1'b0;
        waitRun(DLY);
        fetchModel("t4_fetch_first", 0);
        fetchModel("t4_fetch_last", DEPTH - 1);
        checkOutput("t4_last_value", model[DEPTH-1], 32'hA000_03FF);
        applyStimulus(1'b1, 32'h0000_1000);
        checkOutput("t4_fetch_oob", rom_data_o, 32'h0);
        checkOutput("t4_err_sticky", {31'b0, load_err_o}, 32'd1);

        // Single-word reload issued from RUN
        applyStimulus(1'b1, 32'h0);
        startLoad(1);
        checkOutput("t5_cpu_rst_rise", {31'b0, cpu_rst_o}, 32'd1);
        checkOutput("t5_data_nop", rom_data_o, 32'h0);
        streamWords(1, 1'b0, 32'h1234_5678);
        waitRun(DLY);
        fetchModel("t5_fetch0", 0);
        fetchModel("t5_fetch1", 1);

        // Reset in the middle of a load, then a clean restart
        startLoad(4);
        streamWords(2, 1'b0, 32'hB000_0000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("t6_ready", {31'b0, load_ready_o}, 32'd0);
        checkOutput("t6_cpu_rst", {31'b0, cpu_rst_o}, 32'd1);
        checkOutput("t6_err_cleared", {31'b0, load_err_o}, 32'd0);
        checkOutput("t6_done", {31'b0, load_done_o}, 32'd0);
        step();
        checkOutput("t6_idle_ready", {31'b0, load_ready_o}, 32'd0);
        startLoad(4);
        streamWords(4, 1'b0, 32'hC000_0000);
        waitRun(DLY);
        for (int i = 0; i < 4; i++) fetchModel($sformatf("t6_fetch%0d", i), i);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'(i) << 2);
            checkOutput($sformatf("t6_ce_off%0d", i), rom_data_o, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
